// File: rtl/sci_pkg.sv
// Shared constants for the single-cycle-issue add datapath sequencer.
// Optional feature macro: SCI_CTRL_SINGLE_STEP_EN (adds the PAUSE state).
package sci_pkg;

  // Binary-encoded sequencer states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
`ifdef SCI_CTRL_SINGLE_STEP_EN
    S_HALT   = 3'd5,
    S_PAUSE  = 3'd6
`else
    S_HALT   = 3'd5
`endif
  } state_e;

  // Opcode field instr[31:26].
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // R-type funct field instr[5:0].
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;

  // ALU operation select, same encoding the alu consumes.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Result of decoding one instruction word.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       legal;
    logic       is_halt;
  } dec_t;

endpackage

// File: rtl/sci_decode.sv
// Combinational instruction decoder: opcode/funct -> alu_op, legal, is_halt.
module sci_decode
  import sci_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  // HALT wins over everything; only the four R-type functs are legal.
  always_comb begin
    dec_o = '{alu_op: ALU_ADD, legal: 1'b0, is_halt: 1'b0};
    if (opcode_i == OP_HALT) begin
      dec_o.is_halt = 1'b1;
    end else if (opcode_i == OP_RTYPE) begin
      case (funct_i)
        F_ADD:   dec_o = '{alu_op: ALU_ADD, legal: 1'b1, is_halt: 1'b0};
        F_SUB:   dec_o = '{alu_op: ALU_SUB, legal: 1'b1, is_halt: 1'b0};
        F_AND:   dec_o = '{alu_op: ALU_AND, legal: 1'b1, is_halt: 1'b0};
        F_OR:    dec_o = '{alu_op: ALU_OR,  legal: 1'b1, is_halt: 1'b0};
        default: dec_o = '{alu_op: ALU_ADD, legal: 1'b0, is_halt: 1'b0};
      endcase
    end
  end

endmodule

// File: rtl/sci_ctrl.sv
// Multicycle sequencer: one clock, one-hot stage strobes FETCH/DECODE/EXEC/WB,
// R-type decode into alu_op, gated writeback, retired-instruction counter.
// Optional feature macro: SCI_CTRL_SINGLE_STEP_EN (adds step input and PAUSE).
module sci_ctrl
  import sci_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_INSTR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SCI_CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [31:0]      instr,
  output logic             pc_en,
  output logic             instr_en,
  output logic             rf_rd_en,
  output logic             alu_en,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             wr_q, wr_d;     // legal and rd != 0, captured in DECODE
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             limit_hit;
  dec_t             dec;

  // Fields not consumed by the sequencer (rs, rt, shamt).
  logic unused_instr;
  assign unused_instr = ^{instr[25:16], instr[10:6]};

  sci_decode u_dec (
    .opcode_i (instr[31:26]),
    .funct_i  (instr[5:0]),
    .dec_o    (dec)
  );

  // Saturating increment and optional retire limit on the post-increment value.
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign limit_hit = (MAX_INSTR != 0) && (cnt_inc == CNT_W'(MAX_INSTR));

  // State and datapath-control registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= ALU_ADD;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wr_q    <= wr_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic plus decode capture and retire counting.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wr_d    = wr_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (dec.is_halt) begin
          state_d = S_HALT;
        end else begin
          op_d    = dec.alu_op;
          wr_d    = dec.legal && (instr[15:11] != 5'd0);
          ill_d   = ill_q | ~dec.legal;
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        cnt_d = cnt_inc;
        if (limit_hit)
          state_d = S_HALT;
        else
`ifdef SCI_CTRL_SINGLE_STEP_EN
          state_d = S_PAUSE;
`else
          state_d = S_FETCH;
`endif
      end
`ifdef SCI_CTRL_SINGLE_STEP_EN
      S_PAUSE:  if (step) state_d = S_FETCH;
`endif
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore strobes decoded from the state register only.
  always_comb begin
    instr_en  = (state_q == S_FETCH);
    rf_rd_en  = (state_q == S_DECODE);
    alu_en    = (state_q == S_EXEC);
    pc_en     = (state_q == S_WB);
    reg_write = (state_q == S_WB) && wr_q;
    busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    halted    = (state_q == S_HALT);
  end

  assign alu_op      = op_q;
  assign illegal     = ill_q;
  assign instr_count = cnt_q;

endmodule
